// File: rtl/booth_pkg.sv
// -----------------------------------------------------------------------------
// booth_pkg
// Shared definitions for the Booth multiplier scheduler:
//   - default operand / product widths and operand-queue depth
//   - scheduler FSM state encoding (IDLE, ISSUE, SETTLE, WAIT)
// -----------------------------------------------------------------------------
package booth_pkg;

  localparam int unsigned BOOTH_A_W        = 8;
  localparam int unsigned BOOTH_B_W        = 8;
  localparam int unsigned BOOTH_OUT_W      = BOOTH_A_W + BOOTH_B_W;
  localparam int unsigned BOOTH_FIFO_DEPTH = 4;

  // Encodings are fixed so the state register matches the legacy
  // two-bit encoding 0..3 when probed on a bus.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    SETTLE = 2'd2,
    WAIT   = 2'd3
  } booth_state_e;

endpackage : booth_pkg

// File: rtl/booth_op_fifo.sv
// -----------------------------------------------------------------------------
// booth_op_fifo
// Operand-pair queue for the Booth scheduler. Synchronous FIFO, first-word
// fall-through: data_o always shows the head entry while not empty.
//
// Parameters:
//   WIDTH   entry width in bits
//   DEPTH   number of entries, power of two and at least 2
//
// Ports:
//   clk      in   clock
//   rst      in   synchronous active-high reset (pointers and count only)
//   push_i   in   write data_i this cycle (ignored when full)
//   pop_i    in   drop head entry this cycle (ignored when empty)
//   data_i   in   WIDTH  entry to write
//   data_o   out  WIDTH  head entry
//   full_o   out  queue holds DEPTH entries
//   empty_o  out  queue holds no entries
//   count_o  out  $clog2(DEPTH)+1  occupancy
// -----------------------------------------------------------------------------
module booth_op_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic [WIDTH-1:0]           data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  assign full_o  = (cnt_q == CNT_W'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = mem_q[rd_ptr_q];

  // A push is refused when full even if a pop happens in the same cycle,
  // so the full flag never depends on the consumer in the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Power-of-two depth: pointer overflow is the modulo wrap.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    unique case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage carries no reset; stale entries are unreachable once the
  // pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule : booth_op_fifo

// File: rtl/booth_mult_sched.sv
// -----------------------------------------------------------------------------
// booth_mult_sched
// Feeds signed operand pairs from a small queue to an external sequential
// Booth multiplier and holds each product in a valid/ready result register.
//
// Parameters:
//   MUL_A_W     multiplier (A) operand width
//   MUL_B_W     multiplicand (B) operand width
//   MUL_OUT_W   product width (normally MUL_A_W+MUL_B_W)
//   FIFO_DEPTH  operand queue depth, power of two and at least 2
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   s_valid_i     in   operand pair valid
//   s_ready_o     out  queue can accept (not full)
//   s_a_i/s_b_i   in   signed operands A / B
//   mul_valid_o   out  one-cycle start pulse to the multiplier
//   mul_a_o/_b_o  out  operands to the multiplier (held between issues)
//   mul_done_i    in   multiplier idle/done level
//   mul_prod_i    in   multiplier product
//   m_valid_o     out  result valid
//   m_ready_i     in   downstream accepts the result
//   m_prod_o      out  signed product
//   busy_o        out  FSM not idle or queue non-empty
//   fifo_cnt_o    out  queue occupancy
// -----------------------------------------------------------------------------
module booth_mult_sched
  import booth_pkg::*;
#(
  parameter int unsigned MUL_A_W    = BOOTH_A_W,
  parameter int unsigned MUL_B_W    = BOOTH_B_W,
  parameter int unsigned MUL_OUT_W  = BOOTH_OUT_W,
  parameter int unsigned FIFO_DEPTH = BOOTH_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          s_valid_i,
  output logic                          s_ready_o,
  input  logic [MUL_A_W-1:0]            s_a_i,
  input  logic [MUL_B_W-1:0]            s_b_i,
  output logic                          mul_valid_o,
  output logic [MUL_A_W-1:0]            mul_a_o,
  output logic [MUL_B_W-1:0]            mul_b_o,
  input  logic                          mul_done_i,
  input  logic [MUL_OUT_W-1:0]          mul_prod_i,
  output logic                          m_valid_o,
  input  logic                          m_ready_i,
  output logic [MUL_OUT_W-1:0]          m_prod_o,
  output logic                          busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt_o
);

  localparam int unsigned OP_W  = MUL_A_W + MUL_B_W;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  // ---------------------------------------------------------------------------
  // Operand queue
  // ---------------------------------------------------------------------------
  logic             fifo_push;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [OP_W-1:0]  fifo_head;
  logic [CNT_W-1:0] fifo_cnt;

  booth_state_e state_q, state_d;

  assign s_ready_o  = !fifo_full;
  assign fifo_push  = s_valid_i && !fifo_full;
  // The head was copied to mul_a/b on entry to ISSUE; drop it now.
  assign fifo_pop   = (state_q == ISSUE);
  assign fifo_cnt_o = fifo_cnt;

  booth_op_fifo #(
    .WIDTH (OP_W),
    .DEPTH (FIFO_DEPTH)
  ) u_op_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .data_i  ({s_a_i, s_b_i}),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  // ---------------------------------------------------------------------------
  // Issue FSM
  // ---------------------------------------------------------------------------
  logic               mul_valid_q, mul_valid_d;
  logic [MUL_A_W-1:0] mul_a_q, mul_a_d;
  logic [MUL_B_W-1:0] mul_b_q, mul_b_d;
  logic               m_valid_q, m_valid_d;
  logic [MUL_OUT_W-1:0] m_prod_q, m_prod_d;
  logic               capture;

  // Capture only when the result slot is empty or being drained this cycle;
  // otherwise WAIT holds and the multiplier keeps its product stable.
  assign capture = (state_q == WAIT) && mul_done_i && (!m_valid_q || m_ready_i);

  // mul_valid and the operands are loaded on the IDLE->ISSUE transition so
  // they are registered and coincide exactly with the ISSUE cycle.
  always_comb begin
    state_d     = state_q;
    mul_valid_d = 1'b0;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty && mul_done_i) begin
          state_d              = ISSUE;
          mul_valid_d          = 1'b1;
          {mul_a_d, mul_b_d}   = fifo_head;
        end
      end
      ISSUE: begin
        state_d = SETTLE;
      end
      // The multiplier's done level may still be stale in this cycle.
      SETTLE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (capture) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Result register
  // ---------------------------------------------------------------------------
  always_comb begin
    m_valid_d = m_valid_q;
    m_prod_d  = m_prod_q;
    if (capture) begin
      m_valid_d = 1'b1;
      m_prod_d  = mul_prod_i;
    end else if (m_ready_i) begin
      m_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      mul_valid_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      m_valid_q   <= 1'b0;
      m_prod_q    <= '0;
    end else begin
      state_q     <= state_d;
      mul_valid_q <= mul_valid_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      m_valid_q   <= m_valid_d;
      m_prod_q    <= m_prod_d;
    end
  end

  assign mul_valid_o = mul_valid_q;
  assign mul_a_o     = mul_a_q;
  assign mul_b_o     = mul_b_q;
  assign m_valid_o   = m_valid_q;
  assign m_prod_o    = m_prod_q;
  assign busy_o      = (state_q != IDLE) || !fifo_empty;

endmodule : booth_mult_sched
